booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; must be even and at least 4.
REQ-002 SHALL have port clock, input, 1 bit, single rising-edge clock for all state.
REQ-003 SHALL have port clear, input, 1 bit, reset that is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a multiply.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 means two's-complement operands, 0 means unsigned operands.
REQ-006 SHALL have port multiplicand, input, WIDTH bits, operand A.
REQ-007 SHALL have port multiplier, input, WIDTH bits, operand B.
REQ-008 SHALL have port product, output, 2*WIDTH bits, registered result.
REQ-009 SHALL have port busy, output, 1 bit, high while a multiply is in progress.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse when product becomes valid.

Function
REQ-011 SHALL implement radix-4 Booth recoding over the multiplier, extended to WIDTH+2 bits.
- Extension uses sign bits when is_signed=1 and zero bits when is_signed=0.
- The multiplicand SHALL be extended the same way.
REQ-012 SHALL run a state machine with states IDLE, BUSY and DONE.
- IDLE -> BUSY on start.
- BUSY -> DONE after N = WIDTH/2+1 iterations.
- DONE -> IDLE by default, or DONE -> BUSY if start is high.
REQ-013 SHALL latch multiplicand, multiplier and is_signed only at the edge where start is sampled high in IDLE or DONE.
REQ-014 SHALL ignore start while in BUSY, leaving the operation in progress unaffected.
REQ-015 SHALL process one Booth digit per cycle in BUSY.
- Digit set is {-2,-1,0,+1,+2} times the extended multiplicand.
- Each iteration adds the digit term, then arithmetic-shifts the accumulator/multiplier pair right by 2.
REQ-016 SHALL have fixed latency when CONFIG is disabled: done is high during the cycle following edge E0+N+1, where E0 is the start edge (edge 18 for WIDTH=32).
REQ-017 SHALL drive busy high from edge E0 through the last BUSY cycle; busy and done SHALL never both be high.
REQ-018 SHALL update product only at the BUSY->DONE transition and hold it stable until the next completion.
REQ-019 SHALL produce a product equal to the exact 2*WIDTH-bit signed or unsigned product, with no overflow for any operand pair.
- Includes most-negative times most-negative, and all-ones times all-ones unsigned.
REQ-020 SHALL support back-to-back operation: start high during DONE begins a new multiply at that edge with no idle cycle.

Reset
REQ-021 SHALL, on clear high at a rising edge, force state to IDLE and product, busy and done to 0.
REQ-022 SHALL give clear priority over start, aborting any operation in progress; no done pulse is produced for the aborted operation.
REQ-023 SHALL accept start at the first edge after clear deasserts.

Configuration
REQ-024 SHALL use macro BOOTH_MUL_SEQ_EARLY_TERM_EN to enable early termination.
REQ-025 SHALL, with BOOTH_MUL_SEQ_EARLY_TERM_EN defined, end BUSY early once every remaining multiplier bit plus the overlap bit is all-0 or all-1.
- The remaining digits are all zero in that case.
- The accumulator is arithmetic-shifted right by 2 times the number of remaining iterations in the final cycle.
- Result is identical to REQ-019; minimum latency is 1 BUSY cycle.
REQ-026 SHALL, without the macro, use the fixed N-iteration latency of REQ-016 for all operands.

Verification
REQ-027 Signed: is_signed=1, A=123, B=456, WIDTH=32 -> product=56088; done at edge E0+18 when the macro is undefined; earlier when it is defined.
REQ-028 Signed and unsigned extremes:
- is_signed=1, A=0x80000000, B=0x80000000 -> product=0x4000000000000000.
- is_signed=0, A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-029 Mixed signs: is_signed=1, A=-444, B=-333 -> product=147852; then back-to-back with start held high in DONE, A=789, B=-321 -> product=-253269, with no idle cycle between operations.
REQ-030 Abort: start with A=55, B=13, then clear high at E0+5 -> product=0, busy=0, and no done pulse; the next start with A=7, B=6 -> product=42.
REQ-031 Start ignored while busy: pulse start with A=1, B=1 during BUSY of an operation with A=3, B=5 -> product=15 and exactly one done pulse.
REQ-032 Random regression: 1000 random operand pairs at WIDTH=32 and WIDTH=8 in both is_signed modes -> each product matches the reference multiply in the bench.

Source files
------------

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_seq
// Purpose  : Sequential radix-4 Booth multiplier, signed or unsigned operands,
//            one Booth digit per clock, exact 2*WIDTH-bit product.
// Options  : BOOTH_MUL_SEQ_EARLY_TERM_EN - finish as soon as every remaining
//            Booth digit is zero (variable latency, same result).
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
   parameter int WIDTH = 32            // even, >= 4
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   // Operands are extended by two bits so unsigned values become positive
   // two's-complement numbers and the digit count (WIDTH+2)/2 is integral.
   localparam int c_xw  = WIDTH + 2;            // extended operand width
   localparam int c_aw  = WIDTH + 4;            // accumulator: holds +-2*M sums
   localparam int c_fw  = c_aw + c_xw;          // accumulator:low concatenation
   localparam int c_n   = WIDTH / 2 + 1;        // Booth digits per multiply
   localparam int c_cw  = $clog2(c_n + 1);      // counts 0..c_n

   localparam logic [c_cw-1:0] c_cnt_n = c_cw'(c_n);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_busy = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   logic [1:0]          state_q,   state_d;
   logic [c_xw-1:0]     mcand_q,   mcand_d;
   logic [c_xw-1:0]     mplr_q,    mplr_d;
   logic [c_xw-1:0]     low_q,     low_d;
   logic [c_aw-1:0]     acc_q,     acc_d;
   logic                ovl_q,     ovl_d;
   logic [c_cw-1:0]     cnt_q,     cnt_d;
   logic [2*WIDTH-1:0]  product_q, product_d;

   logic                w_load;
   logic                w_last;
   logic                w_zero_tail;
   logic                w_finish;
   logic [c_xw-1:0]     w_a_ext;
   logic [c_xw-1:0]     w_b_ext;
   logic [c_aw-1:0]     w_mx;
   logic [c_aw-1:0]     w_term;
   logic [c_aw-1:0]     w_sum;
   logic signed [c_fw-1:0] w_cat_next;
   logic [2*WIDTH-1:0]  w_prod;
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
   logic [c_xw:0]       w_tail;
   logic [c_cw-1:0]     w_rem;
   logic [c_cw:0]       w_shamt;
   logic signed [c_fw-1:0] w_cat_cur;
`endif

   // Datapath: operand extension, Booth digit selection, add and shift
   always_comb begin
      w_a_ext = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                          : {2'b00, multiplicand};
      w_b_ext = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                          : {2'b00, multiplier};
      w_load  = start && ((state_q == c_idle) || (state_q == c_done));
      w_last  = (cnt_q == c_cnt_n);

      w_mx = {{2{mcand_q[c_xw-1]}}, mcand_q};
      unique case ({mplr_q[1:0], ovl_q})
         3'b001, 3'b010: w_term = w_mx;
         3'b011:         w_term = w_mx << 1;
         3'b100:         w_term = -(w_mx << 1);
         3'b101, 3'b110: w_term = -w_mx;
         default:        w_term = '0;
      endcase
      w_sum      = acc_q + w_term;
      w_cat_next = {w_sum, low_q};

`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
      // Remaining multiplier bits plus overlap all equal => all digits zero;
      // the outstanding shifts are applied in one step.
      w_tail      = {mplr_q, ovl_q};
      w_zero_tail = (&w_tail) | ~(|w_tail);
      w_rem       = c_cnt_n - cnt_q;
      w_shamt     = {w_rem, 1'b0};
      w_cat_cur   = {acc_q, low_q};
      w_prod      = (2*WIDTH)'(w_cat_cur >>> w_shamt);
`else
      w_zero_tail = 1'b0;
      w_prod      = {acc_q[2*WIDTH-c_xw-1:0], low_q};
`endif
      w_finish = (state_q == c_busy) && (w_last || w_zero_tail);

      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      low_d     = low_q;
      acc_d     = acc_q;
      ovl_d     = ovl_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      if (w_load) begin
         mcand_d = w_a_ext;
         mplr_d  = w_b_ext;
         acc_d   = '0;
         low_d   = '0;
         ovl_d   = 1'b0;
         cnt_d   = '0;
      end else if (state_q == c_busy) begin
         if (w_finish) begin
            product_d = w_prod;
         end else begin
            {acc_d, low_d} = w_cat_next >>> 2;
            mplr_d         = $signed(mplr_q) >>> 2;
            ovl_d          = mplr_q[1];
            cnt_d          = cnt_q + 1'b1;
         end
      end
   end

   // Next-state logic: start is only honoured outside BUSY
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         c_idle:  if (start) state_d = c_busy;
         c_busy:  if (w_finish) state_d = c_done;
         c_done:  state_d = start ? c_busy : c_idle;
         default: state_d = c_idle;
      endcase
   end

   // State register; clear overrides everything, aborting any multiply
   always_ff @(posedge clock) begin
      if (clear) state_q <= c_idle;
      else       state_q <= state_d;
   end

   // Datapath and result registers
   always_ff @(posedge clock) begin
      if (clear) begin
         mcand_q   <= '0;
         mplr_q    <= '0;
         low_q     <= '0;
         acc_q     <= '0;
         ovl_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         low_q     <= low_d;
         acc_q     <= acc_d;
         ovl_q     <= ovl_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Outputs decoded from the state register
   always_comb begin
      busy    = (state_q == c_busy);
      done    = (state_q == c_done);
      product = product_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_seq
// Purpose  : Self-checking bench for booth_mul_seq at WIDTH=32 and WIDTH=8
//            using directed vectors and random operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

   logic        clock = 1'b0;
   logic        clear = 1'b1;

   logic        start32 = 1'b0, sg32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [63:0] prod32;
   logic        busy32, done32;

   logic        start8 = 1'b0, sg8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] prod8;
   logic        busy8, done8;

   int n_total = 0;
   int n_bad   = 0;
   int overlap = 0;
   int hold_err = 0;

   always #5 clock = ~clock;

   booth_mul_seq #(.WIDTH(32)) u_dut32 (
      .clock(clock), .clear(clear), .start(start32), .is_signed(sg32),
      .multiplicand(a32), .multiplier(b32),
      .product(prod32), .busy(busy32), .done(done32)
   );

   booth_mul_seq #(.WIDTH(8)) u_dut8 (
      .clock(clock), .clear(clear), .start(start8), .is_signed(sg8),
      .multiplicand(a8), .multiplier(b8),
      .product(prod8), .busy(busy8), .done(done8)
   );

   // busy and done must never be high together
   always @(negedge clock) begin
      if (busy32 && done32) overlap++;
      if (busy8 && done8)   overlap++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Start one 32-bit multiply, wait for done; lat = edges from start to done
   task automatic mul32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat);
      logic [63:0] p0;
      @(negedge clock);
      start32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
      p0 = prod32;
      @(posedge clock); #1;
      start32 = 1'b0;
      lat = 0;
      while (!done32 && lat < 100) begin
         if (prod32 !== p0) hold_err++;
         @(posedge clock); #1;
         lat++;
      end
      if (lat >= 100) check("timeout32", 64'(lat), 64'd0);
      p = prod32;
   endtask

   task automatic mul8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
      logic [15:0] p0;
      @(negedge clock);
      start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
      p0 = prod8;
      @(posedge clock); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 100) begin
         if (prod8 !== p0) hold_err++;
         @(posedge clock); #1;
         lat++;
      end
      if (lat >= 100) check("timeout8", 64'(lat), 64'd0);
      p = prod8;
   endtask

   task automatic lat32(input string tag, input int lat);
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
      check(tag, 64'(lat <= 18 && lat >= 1), 64'd1);
`else
      check(tag, 64'(lat), 64'd18);
`endif
   endtask

   initial begin
      logic [63:0] p;
      logic [15:0] p8;
      logic [63:0] r64;
      logic [15:0] r16;
      logic [31:0] ra, rb;
      logic [7:0]  ra8, rb8;
      logic        rs;
      int          lat;
      int          pulses;
      logic [63:0] seen;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_prod", prod32, 64'd0);
      check("rst_busy", 64'(busy32), 64'd0);
      check("rst_done", 64'(done32), 64'd0);
      check("rst_prod8", 64'(prod8), 64'd0);
      clear = 1'b0;   // start is applied at the very next edge

      mul32(1'b1, 32'd123, 32'd456, p, lat);
      check("s_123x456", p, 64'd56088);
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
      check("lat_early", 64'(lat < 18), 64'd1);
`else
      check("lat_fixed", 64'(lat), 64'd18);
`endif
      @(posedge clock); #1;
      check("done_pulse", 64'(done32), 64'd0);

      mul32(1'b1, 32'h8000_0000, 32'h8000_0000, p, lat);
      check("s_minxmin", p, 64'h4000_0000_0000_0000);
      lat32("lat_minxmin", lat);
      mul32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
      check("u_onesxones", p, 64'hFFFF_FFFE_0000_0001);
      lat32("lat_ones", lat);

      // mixed signs, then back-to-back from DONE
      mul32(1'b1, -32'sd444, -32'sd333, p, lat);
      check("s_neg_neg", p, 64'd147852);
      mul32(1'b1, 32'd789, -32'sd321, p, lat);
      check("s_b2b", p, -64'sd253269);
      lat32("lat_b2b", lat);
      @(posedge clock); #1;

      // abort with clear at E0+5
      @(negedge clock);
      start32 = 1'b1; sg32 = 1'b1; a32 = 32'd55; b32 = 32'd13;
      @(posedge clock); #1;
      start32 = 1'b0;
      pulses = 0;
      repeat (4) begin
         @(posedge clock); #1;
         if (done32) pulses++;
      end
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
`ifndef BOOTH_MUL_SEQ_EARLY_TERM_EN
      check("abort_nodone", 64'(pulses), 64'd0);
`endif
      check("abort_prod", prod32, 64'd0);
      check("abort_busy", 64'(busy32), 64'd0);
      check("abort_done", 64'(done32), 64'd0);
      clear = 1'b0;
      mul32(1'b1, 32'd7, 32'd6, p, lat);
      check("post_abort", p, 64'd42);
      lat32("lat_post_abort", lat);
      @(posedge clock); #1;

      // start ignored while busy
      @(negedge clock);
      start32 = 1'b1; sg32 = 1'b1; a32 = 32'd3; b32 = 32'd5;
      @(posedge clock); #1;
      start32 = 1'b0; a32 = 32'd1; b32 = 32'd1;
      @(negedge clock);
      start32 = 1'b1;
      @(posedge clock); #1;
      start32 = 1'b0;
      pulses = 0;
      seen = '0;
      repeat (30) begin
         @(posedge clock); #1;
         if (done32) begin
            pulses++;
            seen = prod32;
         end
      end
      check("ign_pulses", 64'(pulses), 64'd1);
      check("ign_prod", seen, 64'd15);

      // 8-bit extremes
      mul8(1'b1, 8'h80, 8'h80, p8, lat);
      check("s8_minxmin", 64'(p8), 64'h4000);
      mul8(1'b0, 8'hFF, 8'hFF, p8, lat);
      check("u8_onesxones", 64'(p8), 64'hFE01);
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
      check("lat8", 64'(lat <= 6), 64'd1);
`else
      check("lat8", 64'(lat), 64'd6);
`endif
      mul8(1'b1, 8'hFD, 8'd7, p8, lat);
      check("s8_m3x7", 64'(p8), 64'hFFEB);

      // random regression
      for (int i = 0; i < 1000; i++) begin
         rs = i[0];
         ra = $urandom; rb = $urandom;
         if (i % 97 == 3) rb = 32'd0;
         if (i % 89 == 5) rb = 32'hFFFF_FFFF;
         r64 = rs ? ({{32{ra[31]}}, ra} * {{32{rb[31]}}, rb})
                  : ({32'd0, ra} * {32'd0, rb});
         mul32(rs, ra, rb, p, lat);
         check("rnd32", p, r64);
      end
      for (int i = 0; i < 1000; i++) begin
         rs = i[0];
         ra8 = 8'($urandom); rb8 = 8'($urandom);
         r16 = rs ? ({{8{ra8[7]}}, ra8} * {{8{rb8[7]}}, rb8})
                  : ({8'd0, ra8} * {8'd0, rb8});
         mul8(rs, ra8, rb8, p8, lat);
         check("rnd8", 64'(p8), 64'(r16));
      end

      @(posedge clock); #1;
      check("busy_done_overlap", 64'(overlap), 64'd0);
      check("product_hold", 64'(hold_err), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
